// File: rtl/fetch_controller_if.sv
// fetch_controller_if: program-memory port and decoder handshake bundle
// Ports: mem_req/mem_addr out, mem_ack/mem_data in; op_valid/op_pc out, op_ready in
// (directions as seen by the fetch controller through the master modport)
interface fetch_controller_if #(parameter int ADDR_W = 16);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic              op_valid;
  logic              op_ready;
  logic [ADDR_W-1:0] op_pc;
  modport master (output mem_req, mem_addr, op_valid, op_pc, input mem_ack, mem_data, op_ready);
  modport slave (input mem_req, mem_addr, op_valid, op_pc, output mem_ack, mem_data, op_ready);
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: fetches variable-length opcodes into the instruction register and issues them to decode
// Ports: clk, rst (async active-low), run, bus (memory + decoder handshake),
// ir_clr/ir_en/ir_wrd (instruction register strobes), jmp_valid/jmp_addr (redirect), busy
module fetch_controller #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  fetch_controller_if.master bus,
  output logic              ir_clr,
  output logic              ir_en,
  output logic [7:0]        ir_wrd,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, START, FETCH, ISSUE} state_t;
  state_t            state, nxt;
  logic [ADDR_W-1:0] pc, op_pc;
  logic [1:0]        byte_cnt, len, dlen, cur_len;
  logic              done;
  assign ir_en        = bus.mem_req & bus.mem_ack & ~jmp_valid;
  assign ir_wrd       = bus.mem_data;
  assign bus.mem_addr = pc;
  assign bus.op_pc    = op_pc;
  // Length from the top two bits of the first byte; 11 is clamped to 3
  assign dlen    = &bus.mem_data[7:6] ? 2'd3 : 2'(bus.mem_data[7:6] + 2'd1);
  // The first byte must use the freshly decoded length, len is not loaded yet
  assign cur_len = byte_cnt == 2'd0 ? dlen : len;
  assign done    = ir_en && 2'(byte_cnt + 2'd1) == cur_len;
  always_comb
    nxt = jmp_valid      ? ((state == IDLE || !run) ? IDLE : START) :
          state == IDLE  ? (run ? START : IDLE) :
          state == START ? FETCH :
          state == FETCH ? (done ? ISSUE : FETCH) :
          bus.op_ready   ? (run ? START : IDLE) : ISSUE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      op_pc        <= RESET_PC;
      byte_cnt     <= '0;
      len          <= 2'd1;
      bus.mem_req  <= 1'b0;
      ir_clr       <= 1'b0;
      bus.op_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= nxt;
      bus.mem_req  <= nxt == FETCH;
      ir_clr       <= nxt == START;
      bus.op_valid <= nxt == ISSUE;
      busy         <= nxt != IDLE;
      if (jmp_valid) pc <= jmp_addr;
      else if (ir_en) pc <= pc + ADDR_W'(1);
      if (state == START && !jmp_valid) begin
        op_pc    <= pc;
        byte_cnt <= '0;
      end else if (ir_en) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd0) len <= dlen;
      end
    end
  end
endmodule
